// File: rtl/mini_pkg.sv
// Shared definitions for the mini DPLL solver.
//   - 2-bit per-variable assignment encoding (UNASSIGNED/TRUE/FALSE)
//   - propagation engine state enum
//   - DIMACS literal helpers: variable index, polarity, evaluation
package mini_pkg;

  localparam logic [1:0] AS_UNASSIGNED = 2'b00;
  localparam logic [1:0] AS_TRUE       = 2'b01;
  localparam logic [1:0] AS_FALSE      = 2'b10;

  typedef enum logic [1:0] {
    PSE_IDLE   = 2'd0,
    PSE_APPLY  = 2'd1,
    PSE_SCAN   = 2'd2,
    PSE_FINISH = 2'd3
  } pse_state_e;

  // |lit|
  function automatic logic [31:0] lit_var(input logic signed [31:0] lit);
    return lit[31] ? 32'(-lit) : 32'(lit);
  endfunction

  // 1 = positive literal
  function automatic logic lit_pol(input logic signed [31:0] lit);
    return ~lit[31];
  endfunction

  // Assignment that makes the literal true
  function automatic logic [1:0] lit_value(input logic signed [31:0] lit);
    return lit_pol(lit) ? AS_TRUE : AS_FALSE;
  endfunction

  // Evaluate a literal against its variable's assign_state entry.
  // Returns AS_TRUE (satisfied), AS_FALSE (falsified) or AS_UNASSIGNED.
  function automatic logic [1:0] lit_eval(input logic signed [31:0] lit,
                                          input logic [1:0]         var_state);
    if (var_state == AS_UNASSIGNED) return AS_UNASSIGNED;
    if (var_state == lit_value(lit)) return AS_TRUE;
    return AS_FALSE;
  endfunction

endpackage

// File: rtl/mini_pse_engine.sv
// Clause store + Boolean constraint propagation engine.
// Loads a CNF clause stream in IDLE, then per start pulse applies one
// decision literal and runs unit propagation (one clause per cycle) to
// fixpoint, keeping an assignment trail that can be popped for backtracking.
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   DEBUG                verbosity hint (no effect on datapath)
//   load_valid/literal/clause_end, load_ready   clause load stream
//   start, decision_var  begin propagation with optional decision literal
//   done, conflict_detected                     completion pulse / result
//   propagated_valid, propagated_var            implied literal stream
//   max_var_seen         largest |literal| stored
//   undo_enable, undo_to_height, trail_height   trail pop interface
// assign_state[] is read hierarchically by the controller.
module mini_pse_engine
  import mini_pkg::*;
#(
  parameter int MAX_VARS       = 256,
  parameter int MAX_CLAUSES    = 256,
  parameter int MAX_LITS       = 2048,
  parameter int MAX_CLAUSE_LEN = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  int                 DEBUG,
  input  logic               load_valid,
  input  logic signed [31:0] load_literal,
  input  logic               load_clause_end,
  output logic               load_ready,
  input  logic               start,
  input  logic signed [31:0] decision_var,
  output logic               done,
  output logic               conflict_detected,
  output logic               propagated_valid,
  output logic signed [31:0] propagated_var,
  output logic [31:0]        max_var_seen,
  input  logic               undo_enable,
  input  logic [15:0]        undo_to_height,
  output logic [15:0]        trail_height
);

  localparam int VW   = (MAX_VARS    > 1) ? $clog2(MAX_VARS)    : 1;
  localparam int CIW  = (MAX_CLAUSES > 1) ? $clog2(MAX_CLAUSES) : 1;
  localparam int CW   = $clog2(MAX_CLAUSES + 1);
  localparam int LIW  = (MAX_LITS    > 1) ? $clog2(MAX_LITS)    : 1;
  localparam int LW   = $clog2(MAX_LITS + 1);
  localparam int LENW = $clog2(MAX_CLAUSE_LEN + 1);

  // Storage
  logic signed [31:0] lit_mem      [MAX_LITS];
  logic [LW-1:0]      clause_start [MAX_CLAUSES];
  logic [LENW-1:0]    clause_len   [MAX_CLAUSES];
  logic [15:0]        trail        [MAX_VARS];
  logic [1:0]         assign_state [0:MAX_VARS-1];

  logic [CW-1:0]      clause_cnt;
  logic [LW-1:0]      lit_cnt;
  logic [LENW-1:0]    cur_len;

  pse_state_e         state;
  logic [CIW-1:0]     scan_idx;
  logic               pass_changed;
  logic signed [31:0] dec_lit;

  // Verbosity only matters to simulation-side reporting.
  logic unused_debug;
  assign unused_debug = ^DEBUG;

  // ---------------------------------------------------------------- load
  logic [31:0] load_v;
  logic        load_acc, lit_store, clause_close;

  assign load_ready   = (state == PSE_IDLE) && (int'(clause_cnt) < MAX_CLAUSES) &&
                        (int'(lit_cnt) < MAX_LITS);
  assign load_v       = lit_var(load_literal);
  assign load_acc     = load_valid && load_ready;
  // Over-long clauses and out-of-range variables are silently dropped.
  assign lit_store    = load_acc && (load_literal != 0) &&
                        (int'(cur_len) < MAX_CLAUSE_LEN) &&
                        (load_v <= 32'(MAX_VARS));
  assign clause_close = load_acc && load_clause_end;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clause_cnt   <= '0;
      lit_cnt      <= '0;
      cur_len      <= '0;
      max_var_seen <= '0;
    end else begin
      if (lit_store) begin
        lit_cnt <= lit_cnt + LW'(1);
        if (load_v > max_var_seen) max_var_seen <= load_v;
      end
      if (clause_close) begin
        clause_cnt <= clause_cnt + CW'(1);
        cur_len    <= '0;
      end else if (lit_store) begin
        cur_len <= cur_len + LENW'(1);
      end
    end
  end

  // ---------------------------------------------------------- clause eval
  logic [LW-1:0]      scan_base;
  logic [LENW-1:0]    scan_len;
  logic signed [31:0] scan_lit;
  logic [1:0]         scan_val;
  logic [LENW-1:0]    n_unassigned;
  logic               any_true;
  logic signed [31:0] unit_lit;
  logic               cl_conflict, cl_unit, scan_last;

  // The whole clause is evaluated in one cycle; unit_lit ends up holding
  // the (only) unassigned literal when the clause is unit.
  always_comb begin
    scan_base    = clause_start[scan_idx];
    scan_len     = clause_len[scan_idx];
    scan_lit     = '0;
    scan_val     = AS_UNASSIGNED;
    n_unassigned = '0;
    any_true     = 1'b0;
    unit_lit     = '0;
    for (int k = 0; k < MAX_CLAUSE_LEN; k++) begin
      if (k < int'(scan_len)) begin
        scan_lit = lit_mem[LIW'(scan_base + LW'(k))];
        scan_val = lit_eval(scan_lit, assign_state[VW'(lit_var(scan_lit) - 32'd1)]);
        if (scan_val == AS_TRUE) begin
          any_true = 1'b1;
        end else if (scan_val == AS_UNASSIGNED) begin
          n_unassigned = n_unassigned + LENW'(1);
          unit_lit     = scan_lit;
        end
      end
    end
  end

  // An empty clause has no literals, so it falls into the conflict case.
  assign cl_conflict = !any_true && (n_unassigned == '0);
  assign cl_unit     = !any_true && (n_unassigned == LENW'(1));
  assign scan_last   = (int'(scan_idx) == int'(clause_cnt) - 1);

  // ------------------------------------------------------------- decision
  logic [31:0] dec_v;
  logic        dec_ok, dec_push, dec_conflict;
  logic [1:0]  dec_st;

  assign dec_v        = lit_var(dec_lit);
  assign dec_ok       = (dec_lit != 0) && (dec_v <= 32'(MAX_VARS));
  assign dec_st       = dec_ok ? assign_state[VW'(dec_v - 32'd1)] : AS_UNASSIGNED;
  assign dec_push     = dec_ok && (dec_st == AS_UNASSIGNED);
  assign dec_conflict = dec_ok && (dec_st != AS_UNASSIGNED) && (dec_st != lit_value(dec_lit));

  // ------------------------------------------------------------ push / pop
  logic               push_en, pop_en;
  logic signed [31:0] push_lit;
  logic [15:0]        pop_var;

  assign push_en  = ((state == PSE_APPLY) && dec_push) ||
                    ((state == PSE_SCAN) && cl_unit);
  assign push_lit = (state == PSE_APPLY) ? dec_lit : unit_lit;
  // start has priority over undo in IDLE.
  assign pop_en   = (state == PSE_IDLE) && !start && undo_enable &&
                    (trail_height > undo_to_height);
  assign pop_var  = trail[VW'(trail_height - 16'd1)];

  // Reset-less storage: contents are meaningless until the counters cover them.
  always_ff @(posedge clk) begin
    if (rst_n && lit_store) lit_mem[LIW'(lit_cnt)] <= load_literal;
    if (rst_n && clause_close) begin
      clause_start[clause_cnt[CIW-1:0]] <= lit_cnt - LW'(cur_len);
      clause_len[clause_cnt[CIW-1:0]]   <= cur_len + LENW'(lit_store);
    end
    if (rst_n && push_en) trail[VW'(trail_height)] <= 16'(lit_var(push_lit));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_VARS; i++) assign_state[i] <= AS_UNASSIGNED;
    end else if (push_en) begin
      assign_state[VW'(lit_var(push_lit) - 32'd1)] <= lit_value(push_lit);
    end else if (pop_en) begin
      assign_state[VW'(pop_var - 16'd1)] <= AS_UNASSIGNED;
    end
  end

  // ------------------------------------------------------------------ FSM
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state             <= PSE_IDLE;
      done              <= 1'b0;
      conflict_detected <= 1'b0;
      propagated_valid  <= 1'b0;
      propagated_var    <= '0;
      trail_height      <= '0;
      scan_idx          <= '0;
      pass_changed      <= 1'b0;
      dec_lit           <= '0;
    end else begin
      done             <= 1'b0;
      propagated_valid <= 1'b0;
      case (state)
        PSE_IDLE: begin
          if (start) begin
            conflict_detected <= 1'b0;
            dec_lit           <= decision_var;
            state             <= PSE_APPLY;
          end else if (pop_en) begin
            trail_height <= trail_height - 16'd1;
          end
        end
        PSE_APPLY: begin
          scan_idx     <= '0;
          pass_changed <= 1'b0;
          if (dec_conflict) begin
            conflict_detected <= 1'b1;
            done              <= 1'b1;
            state             <= PSE_FINISH;
          end else begin
            if (dec_push) trail_height <= trail_height + 16'd1;
            if (clause_cnt == '0) begin
              done  <= 1'b1;
              state <= PSE_FINISH;
            end else begin
              state <= PSE_SCAN;
            end
          end
        end
        PSE_SCAN: begin
          if (cl_conflict) begin
            conflict_detected <= 1'b1;
            done              <= 1'b1;
            state             <= PSE_FINISH;
          end else begin
            if (cl_unit) begin
              trail_height     <= trail_height + 16'd1;
              propagated_valid <= 1'b1;
              propagated_var   <= unit_lit;
            end
            if (scan_last) begin
              // Another pass only if this one changed something.
              if (pass_changed || cl_unit) begin
                scan_idx     <= '0;
                pass_changed <= 1'b0;
              end else begin
                done  <= 1'b1;
                state <= PSE_FINISH;
              end
            end else begin
              scan_idx     <= scan_idx + CIW'(1);
              pass_changed <= pass_changed | cl_unit;
            end
          end
        end
        PSE_FINISH: state <= PSE_IDLE;
        default:    state <= PSE_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mini_pse_engine.sv
// Directed bench for mini_pse_engine with a scoreboard of expected
// done results and propagated literals.
module tb_mini_pse_engine;
  import mini_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          debug = 0;
  logic        load_valid = 1'b0;
  int          load_literal = 0;
  logic        load_clause_end = 1'b0;
  logic        load_ready;
  logic        start = 1'b0;
  int          decision_var = 0;
  logic        done, conflict_detected, propagated_valid;
  int          propagated_var;
  logic [31:0] max_var_seen;
  logic        undo_enable = 1'b0;
  logic [15:0] undo_to_height = '0;
  logic [15:0] trail_height;

  always #5 clk = ~clk;

  mini_pse_engine dut (
    .clk(clk), .rst_n(rst_n), .DEBUG(debug),
    .load_valid(load_valid), .load_literal(load_literal),
    .load_clause_end(load_clause_end), .load_ready(load_ready),
    .start(start), .decision_var(decision_var),
    .done(done), .conflict_detected(conflict_detected),
    .propagated_valid(propagated_valid), .propagated_var(propagated_var),
    .max_var_seen(max_var_seen),
    .undo_enable(undo_enable), .undo_to_height(undo_to_height),
    .trail_height(trail_height)
  );

  int vecs = 0;
  int fails = 0;

  typedef struct {
    logic        conflict;
    logic [15:0] trail;
  } done_exp_t;

  done_exp_t done_q[$];
  int        prop_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Scoreboard: compare DUT events against queued expectations.
  always @(negedge clk) begin
    if (rst_n) begin
      if (propagated_valid) begin
        chk("prop_expected", 32'(prop_q.size() != 0), 32'd1);
        if (prop_q.size() != 0) chk("propagated_var", propagated_var, prop_q.pop_front());
      end
      if (done) begin
        chk("done_expected", 32'(done_q.size() != 0), 32'd1);
        if (done_q.size() != 0) begin
          done_exp_t e;
          e = done_q.pop_front();
          chk("done_conflict", 32'(conflict_detected), 32'(e.conflict));
          chk("done_trail", 32'(trail_height), 32'(e.trail));
        end
      end
    end
  end

  task automatic beat(input int lit, input logic last);
    @(negedge clk);
    load_valid = 1'b1; load_literal = lit; load_clause_end = last;
    @(posedge clk); #1;
    load_valid = 1'b0; load_literal = 0; load_clause_end = 1'b0;
  endtask

  // Pulse start, push the expected done result, measure start->done latency.
  task automatic run_start(input int lit, input logic exp_conf, input int exp_trail,
                           input int exp_lat);
    int cyc;
    done_exp_t e;
    e.conflict = exp_conf;
    e.trail    = 16'(exp_trail);
    done_q.push_back(e);
    @(negedge clk); start = 1'b1; decision_var = lit;
    @(negedge clk); start = 1'b0; decision_var = 0;
    cyc = 1;
    while (!done && cyc < 2000) begin
      @(negedge clk); cyc++;
    end
    chk("done_latency", 32'(cyc), 32'(exp_lat));
  endtask

  task automatic chk_all_unassigned(input string tag);
    logic nz = 1'b0;
    for (int i = 0; i < 256; i++) nz |= (dut.assign_state[i] != AS_UNASSIGNED);
    chk(tag, 32'(nz), 32'd0);
  endtask

  initial begin
    // Reset
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_done", 32'(done), 0);
    chk("rst_conflict", 32'(conflict_detected), 0);
    chk("rst_prop_valid", 32'(propagated_valid), 0);
    chk("rst_prop_var", propagated_var, 0);
    chk("rst_max_var", max_var_seen, 0);
    chk("rst_trail", 32'(trail_height), 0);
    chk("rst_load_ready", 32'(load_ready), 1);
    chk_all_unassigned("rst_assign");

    // No clauses: done at t+2
    run_start(0, 1'b0, 0, 2);

    // (1 2)(-1 2)(-2 3)
    beat(1, 0);  beat(2, 1);
    beat(-1, 0); beat(2, 1);
    beat(-2, 0); beat(3, 1);
    @(negedge clk);
    chk("max_var_3", max_var_seen, 3);
    run_start(0, 1'b0, 0, 5);

    // Decision -2 implies +1, then (-1 2) is falsified
    prop_q.push_back(1);
    run_start(-2, 1'b1, 2, 4);
    chk("as_x1_true", 32'(dut.assign_state[0]), 32'(AS_TRUE));
    chk("as_x2_false", 32'(dut.assign_state[1]), 32'(AS_FALSE));

    // Undo to a height above the trail is ignored
    @(negedge clk); undo_enable = 1'b1; undo_to_height = 16'd5;
    @(negedge clk); undo_enable = 1'b0;
    chk("undo_ignored", 32'(trail_height), 2);
    // Undo to 0 held two cycles
    undo_to_height = 16'd0; undo_enable = 1'b1;
    @(negedge clk);
    chk("undo_step1", 32'(trail_height), 1);
    @(negedge clk);
    chk("undo_step2", 32'(trail_height), 0);
    undo_enable = 1'b0;
    chk_all_unassigned("undo_assign");

    // Unit clause (5): propagated on pass 1, quiescent pass 2
    beat(5, 1);
    @(negedge clk);
    chk("max_var_5", max_var_seen, 5);
    prop_q.push_back(5);
    run_start(0, 1'b0, 1, 10);
    chk("as_x5_true", 32'(dut.assign_state[4]), 32'(AS_TRUE));

    // Decision 3, then contradicting -3 without undo
    run_start(3, 1'b0, 2, 6);
    run_start(-3, 1'b1, 2, 2);
    chk("as_x3_kept", 32'(dut.assign_state[2]), 32'(AS_TRUE));

    // Empty clause is always falsified
    beat(0, 1);
    run_start(0, 1'b1, 2, 7);

    // Fill clause store to capacity (5 loaded so far)
    for (int i = 5; i < 256; i++) beat(0, 1);
    @(negedge clk);
    chk("full_load_ready", 32'(load_ready), 0);

    // Mid-stream reset clears everything including clauses
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst2_load_ready", 32'(load_ready), 1);
    chk("rst2_max_var", max_var_seen, 0);
    chk("rst2_trail", 32'(trail_height), 0);
    chk_all_unassigned("rst2_assign");
    run_start(0, 1'b0, 0, 2);

    repeat (2) @(negedge clk);
    chk("prop_q_drained", 32'(prop_q.size()), 0);
    chk("done_q_drained", 32'(done_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule
